// File: rtl/tag_sched_pkg.sv
// Shared state encoding, width helpers and constants for the tag scheduler.
package tag_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoad  = 3'd1;
  localparam state_t StShift = 3'd2;
  localparam state_t StHold  = 3'd3;
  localparam state_t StDrain = 3'd4;

  // Tag value meaning "no tag" downstream; never issued.
  localparam int unsigned TAG_NONE = 0;

  function automatic int unsigned ncol_width(input int unsigned num_col);
    return $clog2(num_col + 1);
  endfunction

  function automatic int unsigned out_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/tag_credit_ctr.sv
// Tag allocator (wraps past zero) plus in-flight credit counter with sticky underflow flag.
module tag_credit_ctr
  import tag_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned OUT_W          = out_width(MAX_OUTSTANDING)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  input  logic                  retire,
  output logic [DATA_WIDTH-1:0] next_tag,
  output logic [OUT_W-1:0]      outstanding,
  output logic [OUT_W-1:0]      outstanding_nxt,
  output logic                  err_retire
);

  localparam logic [OUT_W-1:0] MaxCnt = OUT_W'(MAX_OUTSTANDING);

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !retire && (outstanding < MaxCnt)) begin
      outstanding_nxt = outstanding + OUT_W'(1);
    end else if (!grant && retire && (outstanding != '0)) begin
      outstanding_nxt = outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tag    <= DATA_WIDTH'(1);
      outstanding <= '0;
      err_retire  <= 1'b0;
    end else begin
      if (grant) begin
        next_tag <= (next_tag == '1) ? DATA_WIDTH'(1) : next_tag + DATA_WIDTH'(1);
      end
      outstanding <= outstanding_nxt;
      if (retire && !grant && (outstanding == '0)) begin
        err_retire <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tag_sched.sv
// Tag shift-chain controller: grants tags to tiles and sequences flush / per-column lock masks.
module tag_sched
  import tag_sched_pkg::*;
#(
  parameter int unsigned NUM_COL         = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HOLD_W          = 16,
  localparam int unsigned NCOL_W         = ncol_width(NUM_COL),
  localparam int unsigned OUT_W          = out_width(MAX_OUTSTANDING)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NCOL_W-1:0]     req_ncol,
  input  logic [HOLD_W-1:0]     req_hold,
  output logic                  grant_valid,
  output logic [DATA_WIDTH-1:0] grant_tag,
  input  logic                  retire,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] tag_in,
  output logic [NUM_COL-1:0]    tag_lock,
  output logic                  busy,
  output logic [OUT_W-1:0]      outstanding,
  output logic                  err_retire
);

  localparam int unsigned CNT_W = (HOLD_W > NCOL_W) ? HOLD_W : NCOL_W;
  localparam logic [OUT_W-1:0] MaxCnt = OUT_W'(MAX_OUTSTANDING);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [NCOL_W-1:0]   ncol_q, ncol_d, ncol_norm;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    ncol_last, hold_last;
  logic [NUM_COL-1:0]  lock_d;
  logic [DATA_WIDTH-1:0] next_tag;
  logic [OUT_W-1:0]    outstanding_nxt;
  logic                accept;

  function automatic logic [NUM_COL-1:0] low_ones(input int unsigned k);
    logic [NUM_COL-1:0] m;
    for (int unsigned i = 0; i < NUM_COL; i++) m[i] = (i < k);
    return m;
  endfunction

  tag_credit_ctr #(
    .DATA_WIDTH      (DATA_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk             (clk),
    .rst             (rst),
    .grant           (state_q == StLoad),
    .retire          (retire),
    .next_tag        (next_tag),
    .outstanding     (outstanding),
    .outstanding_nxt (outstanding_nxt),
    .err_retire      (err_retire)
  );

  assign accept    = req_valid && req_ready;
  assign ncol_norm = ((req_ncol == '0) || (req_ncol > NCOL_W'(NUM_COL))) ? NCOL_W'(NUM_COL)
                                                                       : req_ncol;
  assign ncol_last = CNT_W'(ncol_q) - CNT_W'(1);
  assign hold_last = CNT_W'(hold_q) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ncol_d  = ncol_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          ncol_d  = ncol_norm;
          hold_d  = req_hold;
          state_d = StLoad;
        end
      end
      StLoad: begin
        idx_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (idx_q == ncol_last) begin
          idx_d   = '0;
          state_d = (hold_q != '0) ? StHold : StDrain;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (idx_q == hold_last) begin
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (idx_q == ncol_last) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    lock_d = '0;
    case (state_d)
      StShift: lock_d = low_ones(32'(idx_d) + 32'd1);
      StHold:  lock_d = low_ones(32'(ncol_d));
      StDrain: lock_d = low_ones(32'(ncol_d)) & ~low_ones(32'(idx_d) + 32'd1);
      default: lock_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      ncol_q      <= '0;
      hold_q      <= '0;
      req_ready   <= 1'b0;
      flush       <= 1'b0;
      grant_valid <= 1'b0;
      tag_in      <= DATA_WIDTH'(TAG_NONE);
      grant_tag   <= DATA_WIDTH'(TAG_NONE);
      tag_lock    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ncol_q      <= ncol_d;
      hold_q      <= hold_d;
      req_ready   <= (state_d == StIdle) && (outstanding_nxt < MaxCnt);
      flush       <= (state_d == StLoad);
      grant_valid <= (state_d == StLoad);
      if (state_d == StLoad) begin
        tag_in    <= next_tag;
        grant_tag <= next_tag;
      end
      tag_lock    <= lock_d;
      busy        <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_tag_sched.sv
// Self-checking bench for tag_sched: directed scenarios plus randomized tiles against a
// sequence-level model of lock masks, tags and credits.
module tb_tag_sched;

  localparam int NC = 8;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, grant_valid, retire, flush, busy, err_retire;
  logic [3:0]    req_ncol;
  logic [HW-1:0] req_hold;
  logic [DW-1:0] grant_tag, tag_in;
  logic [NC-1:0] tag_lock;
  logic [2:0]    outstanding;

  // Narrow-tag instance used to exercise tag wrap-around.
  logic       w_req_valid, w_req_ready, w_grant_valid, w_retire, w_flush, w_busy, w_err;
  logic [1:0] w_ncol, w_lock;
  logic [3:0] w_hold;
  logic [2:0] w_grant_tag, w_tag_in;
  logic       w_outstanding;

  int           n_asserts = 0;
  int           n_fail    = 0;
  int unsigned  exp_tag;
  int           out_m;
  bit           err_m;
  logic [NC-1:0] lock_log[$];

  always #5 clk = ~clk;

  tag_sched #(.NUM_COL(NC), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .HOLD_W(HW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_ncol(req_ncol),
    .req_hold(req_hold), .grant_valid(grant_valid), .grant_tag(grant_tag), .retire(retire),
    .flush(flush), .tag_in(tag_in), .tag_lock(tag_lock), .busy(busy),
    .outstanding(outstanding), .err_retire(err_retire)
  );

  tag_sched #(.NUM_COL(2), .DATA_WIDTH(3), .MAX_OUTSTANDING(1), .HOLD_W(4)) dut_w (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_ncol(w_ncol),
    .req_hold(w_hold), .grant_valid(w_grant_valid), .grant_tag(w_grant_tag),
    .retire(w_retire), .flush(w_flush), .tag_in(w_tag_in), .tag_lock(w_lock), .busy(w_busy),
    .outstanding(w_outstanding), .err_retire(w_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] ones(input int k);
    return NC'((1 << k) - 1);
  endfunction

  // Cycle k after LOAD: ramp of n cycles, h full-mask cycles, then drain from the low side.
  function automatic logic [NC-1:0] exp_mask(input int n, input int h, input int k);
    if (k < n) return ones(k + 1);
    if (k < n + h) return ones(n);
    return ones(n) & ~ones(k - n - h + 1);
  endfunction

  task automatic retire_pulse();
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    if (out_m == 0) err_m = 1'b1;
    else out_m--;
    chk("retire_outstanding", outstanding, out_m);
    chk("retire_err", err_retire, err_m);
    chk("retire_ready", req_ready, out_m < MO);
  endtask

  task automatic do_tile(input int n, input int h, input bit ret_load, input int abort_at);
    int ne;
    ne = (n == 0 || n > NC) ? NC : n;
    lock_log.delete();
    req_valid = 1'b1;
    req_ncol  = 4'(n);
    req_hold  = HW'(h);
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("load_flush", flush, 1);
    chk("load_tag_in", tag_in, exp_tag);
    chk("load_grant_valid", grant_valid, 1);
    chk("load_grant_tag", grant_tag, exp_tag);
    chk("load_busy", busy, 1);
    chk("load_lock", tag_lock, 0);
    chk("load_outstanding", outstanding, out_m);
    if (ret_load) retire = 1'b1;
    out_m = out_m + 1 - (ret_load ? 1 : 0);
    for (int k = 0; k < 2 * ne + h; k++) begin
      @(negedge clk);
      retire = 1'b0;
      lock_log.push_back(tag_lock);
      chk("lock", tag_lock, exp_mask(ne, h, k));
      chk("flush_low", flush, 0);
      chk("grant_low", grant_valid, 0);
      chk("tag_in_hold", tag_in, exp_tag);
      chk("busy", busy, 1);
      chk("ready_busy", req_ready, 0);
      chk("outstanding", outstanding, out_m);
      chk("err_retire", err_retire, err_m);
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_lock", tag_lock, 0);
        chk("abort_flush", flush, 0);
        chk("abort_busy", busy, 0);
        chk("abort_outstanding", outstanding, 0);
        chk("abort_ready", req_ready, 0);
        exp_tag = 1;
        out_m   = 0;
        err_m   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_lock", tag_lock, 0);
    chk("end_ready", req_ready, out_m < MO);
    exp_tag = (exp_tag == 32'hFFFF_FFFF) ? 1 : exp_tag + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NC-1:0] seq_exp [8];
    int unsigned   w_exp;
    bit            got;
    seq_exp = '{8'h01, 8'h03, 8'h07, 8'h07, 8'h07, 8'h06, 8'h04, 8'h00};
    rst = 1'b1;
    req_valid = 1'b0; req_ncol = '0; req_hold = '0; retire = 1'b0;
    w_req_valid = 1'b0; w_ncol = '0; w_hold = '0; w_retire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_lock", tag_lock, 0);
    chk("rst_flush", flush, 0);
    chk("rst_tag_in", tag_in, 0);
    chk("rst_grant_tag", grant_tag, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_retire, 0);
    rst = 1'b0;
    @(negedge clk);
    exp_tag = 1; out_m = 0; err_m = 1'b0;

    // Directed ncol=3 hold=2 tile.
    do_tile(3, 2, 1'b0, -1);
    chk("seq_len", lock_log.size(), 8);
    for (int i = 0; i < 8 && i < lock_log.size(); i++) chk("seq_lock", lock_log[i], seq_exp[i]);
    retire_pulse();

    // Out-of-range column counts normalise to the full array.
    do_tile(0, 0, 1'b0, -1);
    retire_pulse();
    do_tile(9, 0, 1'b0, -1);
    retire_pulse();

    // Reset during HOLD aborts the tile.
    do_tile(2, 5, 1'b0, 4);

    // Credit limit: four tiles fill the credits, then one retire frees one.
    for (int i = 0; i < 4; i++) do_tile(int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
                                        1'b0, -1);
    req_valid = 1'b1;
    req_ncol  = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("limit_ready", req_ready, 0);
      chk("limit_busy", busy, 0);
      chk("limit_outstanding", outstanding, 4);
    end
    req_valid = 1'b0;
    retire_pulse();
    chk("fifth_expected_tag", exp_tag, 5);
    do_tile(2, 1, 1'b0, -1);

    // Retire coinciding with LOAD leaves the count unchanged.
    retire_pulse();
    retire_pulse();
    do_tile(1, 0, 1'b1, -1);
    chk("load_retire_outstanding", outstanding, 2);
    retire_pulse();
    retire_pulse();
    retire_pulse();
    repeat (3) @(negedge clk);
    chk("err_sticky", err_retire, 1);

    // Randomized tiles.
    for (int t = 0; t < 12; t++) begin
      if (out_m == MO) retire_pulse();
      do_tile(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
              (out_m > 0) && ($urandom_range(0, 1) == 1), -1);
      if (out_m > 0 && $urandom_range(0, 1) == 1) retire_pulse();
    end

    // Tag wrap on the 3-bit instance: 1..7 then 1 again, never 0.
    w_exp = 1;
    w_req_valid = 1'b1;
    w_ncol = 2'd1;
    w_hold = 4'd0;
    for (int i = 0; i < 9; i++) begin
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(negedge clk);
        if (w_grant_valid) got = 1'b1;
      end
      chk("wrap_grant_seen", got, 1);
      chk("wrap_tag", w_grant_tag, w_exp);
      @(negedge clk);
      w_retire = 1'b1;
      @(negedge clk);
      w_retire = 1'b0;
      w_exp = (w_exp == 7) ? 1 : w_exp + 1;
    end
    w_req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
